wallace_mult_pipe: RTL and testbench
====================================

WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 4..32.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag carried with each operation, legal range 1..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand set is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port b, input, WIDTH bits: multiplier.
REQ-009 SHALL have port is_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned operands; sampled per operation.
REQ-010 SHALL have port in_tag, input, TAG_W bits: sideband tag returned unchanged with the result.
REQ-011 SHALL have port out_valid, output, 1 bit: product and out_tag are valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port product, output, 2*WIDTH bits: the full-width product.
REQ-014 SHALL have port out_tag, output, TAG_W bits: the tag of the operation currently on product.

Function
REQ-015 SHALL be a three-stage pipeline. S1 registers a, b, is_signed and tag. S2 generates partial products and applies Wallace 3:2/2:2 reduction down to two rows (sum and carry), then registers them. S3 runs the final carry-propagate addition and registers product.
REQ-016 SHALL accept an operation on a rising edge when in_valid && in_ready are both high.
REQ-017 SHALL present an operation accepted at edge t on product/out_valid after edge t+2, giving a latency of 3 edges including the accept edge.
REQ-018 SHALL use a single global advance signal, advance = !out_valid || out_ready. All stages shift only when advance is 1, and in_ready = advance.
REQ-019 SHALL hold product, out_tag and out_valid stable while out_valid && !out_ready, and SHALL neither drop nor duplicate any operation.
REQ-020 SHALL carry a per-stage valid bit. A bubble (an advance edge with no accept) SHALL propagate as valid=0.
REQ-021 SHALL compute the unsigned product mod 2^(2*WIDTH) when is_signed=0, and the exact two's-complement product, using Baugh-Wooley sign correction, when is_signed=1. Both results SHALL be exact with no overflow.
REQ-022 SHALL allow is_signed to differ between back-to-back operations, each result using its own mode.
REQ-023 SHALL allow product and out_tag to hold any value while out_valid=0. The bench SHALL NOT check them then.
REQ-024 SHALL sustain throughput of one operation per cycle while out_ready is held at 1.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, clear all stage valid bits. Consequently out_valid=0 and in_ready=1 after that edge.
REQ-026 SHALL drive product=0 and out_tag=0 after reset.
REQ-027 SHALL take priority over in_valid when rst is high: it discards operations in flight and accepts no operation on that edge.

Structure
REQ-028 SHALL place the WIDTH/TAG_W default constants and the stage count (3) in a shared package, wallace_pkg.
REQ-029 SHALL instantiate one sub-module, wallace_csa_row: a parametrised row of 3:2 compressors (full/half adders) used by each reduction level.
REQ-030 SHALL be fully synthesizable, with no latches and no multi-cycle paths.

Verification
REQ-031 SHALL cover this case (WIDTH=8): unsigned 255*255 -> product=16'hFE01 three edges after accept, tag preserved.
REQ-032 SHALL cover this case (WIDTH=8): signed -128*-128 -> 16'h4000; signed -1*1 -> 16'hFFFF; unsigned 8'hFF*1 -> 16'h00FF issued back-to-back. Results SHALL appear on consecutive cycles in order.
REQ-033 SHALL cover this case: a stream of 4 operations with out_ready=0 for 2 cycles mid-stream -> in_ready=0 during the stall, product held, and all 4 results delivered in order with correct tags.
REQ-034 SHALL cover this case: rst asserted with 2 operations in flight -> out_valid=0 and product=0 on the next cycle, and no stale result appears later.
REQ-035 SHALL cover this case (WIDTH=4): exhaustive 256 operand pairs × both modes against a reference model -> zero mismatches.
REQ-036 SHALL cover this case: random in_valid/out_ready at 50% for 10k cycles -> scoreboard match, no loss or duplication.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared constants and elaboration helpers for the pipelined Wallace-tree multiplier.
package wallace_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_TAG_W  = 4;
    localparam int NUM_STAGES = 3;

    // One 3:2 level turns each full triple of rows into two; leftover rows pass through.
    function automatic int next_rows(input int n);
        return 2 * (n / 3) + n % 3;
    endfunction

    function automatic int rows_at(input int n0, input int lvl);
        int n;
        n = n0;
        for (int i = 0; i < lvl; i++) n = next_rows(n);
        return n;
    endfunction

    function automatic int num_levels(input int n0);
        int n;
        int l;
        n = n0;
        l = 0;
        while (n > 2) begin
            n = next_rows(n);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// Row of full adders (3:2 compressors) across a full product-width word.
module wallace_csa_row #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum = x ^ y ^ z;

    // Carries are pre-shifted one column up; the top carry lies outside the modular product.
    assign carry = {(x[WIDTH-2:0] & y[WIDTH-2:0]) |
                    (x[WIDTH-2:0] & z[WIDTH-2:0]) |
                    (y[WIDTH-2:0] & z[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage signed/unsigned multiplier: operand register, Wallace reduction to two rows,
// final carry-propagate add. One global advance stalls every stage together.
module wallace_mult_pipe
    import wallace_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int P    = 2 * WIDTH;
    localparam int NR0  = WIDTH + 1;
    localparam int NLEV = num_levels(NR0);
    localparam logic [P-1:0] BW_CONST = (P'(1) << WIDTH) | (P'(1) << (P - 1));

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("wallace_mult_pipe: WIDTH out of range");
    end
    if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
        $error("wallace_mult_pipe: TAG_W out of range");
    end

    logic             advance;
    logic             v1;
    logic             v2;
    logic             v3;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             sgn1;
    logic [TAG_W-1:0] tag1;
    logic [TAG_W-1:0] tag2;
    logic [P-1:0]     sum2;
    logic [P-1:0]     carry2;
    logic [P-1:0]     tree [NLEV+1][NR0];

    assign advance   = !v3 || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3;

    // Baugh-Wooley: in signed mode, invert every partial-product bit pairing exactly one
    // operand MSB, then add 2^WIDTH + 2^(2*WIDTH-1) through an extra constant row.
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
        localparam logic [WIDTH-1:0] INV = (i == WIDTH - 1) ? {1'b0, {(WIDTH-1){1'b1}}}
                                                            : {1'b1, {(WIDTH-1){1'b0}}};
        logic [WIDTH-1:0] row;
        assign row        = (a1 & {WIDTH{b1[i]}}) ^ (sgn1 ? INV : '0);
        assign tree[0][i] = {{WIDTH{1'b0}}, row} << i;
    end
    assign tree[0][WIDTH] = sgn1 ? BW_CONST : '0;

    for (genvar k = 1; k <= NLEV; k++) begin : g_lvl
        localparam int NP = rows_at(NR0, k - 1);
        localparam int NG = NP / 3;
        localparam int NN = rows_at(NR0, k);
        for (genvar g = 0; g < NG; g++) begin : g_csa
            wallace_csa_row #(.WIDTH(P)) u_row (
                .x    (tree[k-1][3*g]),
                .y    (tree[k-1][3*g+1]),
                .z    (tree[k-1][3*g+2]),
                .sum  (tree[k][2*g]),
                .carry(tree[k][2*g+1])
            );
        end
        for (genvar r = 0; r < NP % 3; r++) begin : g_pass
            assign tree[k][2*NG+r] = tree[k-1][3*NG+r];
        end
        for (genvar u = NN; u < NR0; u++) begin : g_zero
            assign tree[k][u] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            sgn1 <= 1'b0;
            tag1 <= '0;
        end else if (advance) begin
            v1   <= in_valid;
            a1   <= a;
            b1   <= b;
            sgn1 <= is_signed;
            tag1 <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            sum2   <= '0;
            carry2 <= '0;
            tag2   <= '0;
        end else if (advance) begin
            v2     <= v1;
            sum2   <= tree[NLEV][0];
            carry2 <= tree[NLEV][1];
            tag2   <= tag1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3      <= 1'b0;
            product <= '0;
            out_tag <= '0;
        end else if (advance) begin
            v3      <= v2;
            product <= sum2 + carry2;
            out_tag <= tag2;
        end
    end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed and randomized checks of wallace_mult_pipe at WIDTH=8 and WIDTH=4.
module tb_wallace_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv8, ir8, s8, ov8, ordy8;
    logic [7:0]  a8, b8;
    logic [3:0]  tag8, otag8;
    logic [15:0] prod8;
    logic        iv4, ir4, s4, ov4, ordy4;
    logic [3:0]  a4, b4;
    logic [3:0]  tag4, otag4;
    logic [7:0]  prod4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  t;
    } exp_t;

    exp_t q8[$];
    exp_t q4[$];

    wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(s8), .in_tag(tag8), .out_valid(ov8), .out_ready(ordy8),
        .product(prod8), .out_tag(otag8)
    );

    wallace_mult_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .is_signed(s4), .in_tag(tag4), .out_valid(ov4), .out_ready(ordy4),
        .product(prod4), .out_tag(otag4)
    );

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi, yi, p;
        xi = s ? {{24{x[7]}}, x} : {24'b0, x};
        yi = s ? {{24{y[7]}}, y} : {24'b0, y};
        p  = xi * yi;
        return p[15:0];
    endfunction

    function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int xi, yi, p;
        xi = s ? {{28{x[3]}}, x} : {28'b0, x};
        yi = s ? {{28{y[3]}}, y} : {28'b0, y};
        p  = xi * yi;
        return p[7:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; tag8 = '0; ordy8 = 1'b0;
        iv4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; tag4 = '0; ordy4 = 1'b0;
        tick;
        tick;
        total_cnt++;
        if (ov8 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov8); else pass_cnt++;
        total_cnt++;
        if (ir8 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir8); else pass_cnt++;
        total_cnt++;
        if (prod8 !== 16'h0000) $display("FAIL reset_product: got %h want 0000", prod8); else pass_cnt++;
        total_cnt++;
        if (otag8 !== 4'h0) $display("FAIL reset_out_tag: got %h want 0", otag8); else pass_cnt++;
        total_cnt++;
        if (ov4 !== 1'b0 || ir4 !== 1'b1) $display("FAIL reset_w4: got valid=%b ready=%b want 0/1", ov4, ir4); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_unsigned_max;
        ordy8 = 1'b1;
        iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; tag8 = 4'h5;
        tick;
        iv8 = 1'b0;
        total_cnt++;
        if (ov8 !== 1'b0) $display("FAIL max_early_1: got valid=%b want 0", ov8); else pass_cnt++;
        tick;
        total_cnt++;
        if (ov8 !== 1'b0) $display("FAIL max_early_2: got valid=%b want 0", ov8); else pass_cnt++;
        tick;
        total_cnt++;
        if (ov8 !== 1'b1 || prod8 !== 16'hFE01 || otag8 !== 4'h5)
            $display("FAIL max_result: got valid=%b prod=%h tag=%h want 1 fe01 5", ov8, prod8, otag8);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (ov8 !== 1'b0) $display("FAIL max_after: got valid=%b want 0", ov8); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic        vs [3];
        logic [15:0] ve [3];
        va = '{8'h80, 8'hFF, 8'hFF};
        vb = '{8'h80, 8'h01, 8'h01};
        vs = '{1'b1, 1'b1, 1'b0};
        ve = '{16'h4000, 16'hFFFF, 16'h00FF};
        ordy8 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                iv8 = 1'b1; a8 = va[c]; b8 = vb[c]; s8 = vs[c]; tag8 = 4'(c + 1);
            end else begin
                iv8 = 1'b0;
            end
            tick;
            total_cnt++;
            if (c >= 2 && c < 5) begin
                if (ov8 !== 1'b1 || prod8 !== ve[c-2] || otag8 !== 4'(c - 1))
                    $display("FAIL b2b_result_%0d: got valid=%b prod=%h tag=%h want 1 %h %h",
                             c - 2, ov8, prod8, otag8, ve[c-2], 4'(c - 1));
                else pass_cnt++;
            end else begin
                if (ov8 !== 1'b0) $display("FAIL b2b_idle_%0d: got valid=%b want 0", c, ov8); else pass_cnt++;
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic        vs [4];
        logic [15:0] ve [4];
        int ni, nr;
        va = '{8'd3, 8'd7, 8'hFD, 8'd200};
        vb = '{8'd5, 8'd9, 8'd4, 8'd100};
        vs = '{1'b0, 1'b0, 1'b1, 1'b0};
        ve = '{16'h000F, 16'h003F, 16'hFFF4, 16'h4E20};
        ni = 0;
        nr = 0;
        for (int c = 0; c < 16; c++) begin
            ordy8 = !(c == 4 || c == 5);
            if (ni < 4) begin
                iv8 = 1'b1; a8 = va[ni]; b8 = vb[ni]; s8 = vs[ni]; tag8 = 4'(ni + 1);
            end else begin
                iv8 = 1'b0;
            end
            #1;
            if (c == 4 || c == 5) begin
                total_cnt++;
                if (ir8 !== 1'b0) $display("FAIL stall_in_ready_%0d: got %b want 0", c, ir8); else pass_cnt++;
                total_cnt++;
                if (ov8 !== 1'b1 || prod8 !== 16'h003F || otag8 !== 4'h2)
                    $display("FAIL stall_hold_%0d: got valid=%b prod=%h tag=%h want 1 003f 2", c, ov8, prod8, otag8);
                else pass_cnt++;
            end
            if (iv8 && ir8) ni++;
            if (ov8 && ordy8) begin
                total_cnt++;
                if (nr >= 4) $display("FAIL stall_extra: got extra result prod=%h want none", prod8);
                else if (prod8 !== ve[nr] || otag8 !== 4'(nr + 1))
                    $display("FAIL stall_result_%0d: got prod=%h tag=%h want %h %h", nr, prod8, otag8, ve[nr], 4'(nr + 1));
                else pass_cnt++;
                nr++;
            end
            tick;
        end
        iv8 = 1'b0;
        ordy8 = 1'b1;
        total_cnt++;
        if (nr != 4) $display("FAIL stall_count: got %0d results want 4", nr); else pass_cnt++;
    endtask

    task automatic test_reset_in_flight;
        ordy8 = 1'b1;
        iv8 = 1'b1; a8 = 8'd2; b8 = 8'd3; s8 = 1'b0; tag8 = 4'h6;
        tick;
        a8 = 8'd4; b8 = 8'd5; tag8 = 4'h7;
        tick;
        rst = 1'b1; a8 = 8'd6; b8 = 8'd7; tag8 = 4'h8;
        tick;
        total_cnt++;
        if (ov8 !== 1'b0 || prod8 !== 16'h0000 || otag8 !== 4'h0 || ir8 !== 1'b1)
            $display("FAIL rst_flight: got valid=%b prod=%h tag=%h ready=%b want 0 0000 0 1", ov8, prod8, otag8, ir8);
        else pass_cnt++;
        rst = 1'b0;
        iv8 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            total_cnt++;
            if (ov8 !== 1'b0) $display("FAIL rst_stale_%0d: got valid=%b prod=%h want 0", c, ov8, prod8); else pass_cnt++;
        end
    endtask

    task automatic test_exhaustive_w4;
        exp_t e;
        int nr;
        nr = 0;
        ordy4 = 1'b1;
        q4.delete();
        for (int c = 0; c < 520; c++) begin
            if (c < 512) begin
                iv4 = 1'b1; a4 = c[3:0]; b4 = c[7:4]; s4 = c[8]; tag4 = c[5:2];
            end else begin
                iv4 = 1'b0;
            end
            #1;
            if (iv4 && ir4) q4.push_back('{p: {8'h00, ref4(a4, b4, s4)}, t: tag4});
            if (ov4 && ordy4) begin
                total_cnt++;
                if (q4.size() == 0) $display("FAIL w4_extra: got prod=%h want none", prod4);
                else begin
                    e = q4.pop_front();
                    if (prod4 !== e.p[7:0] || otag4 !== e.t)
                        $display("FAIL w4_result_%0d: got prod=%h tag=%h want %h %h", nr, prod4, otag4, e.p[7:0], e.t);
                    else pass_cnt++;
                end
                nr++;
            end
            tick;
        end
        total_cnt++;
        if (nr != 512 || q4.size() != 0) $display("FAIL w4_count: got %0d results want 512", nr); else pass_cnt++;
    endtask

    task automatic test_random;
        exp_t        e;
        logic        held;
        logic [15:0] held_p;
        logic [3:0]  held_t;
        held = 1'b0;
        held_p = '0;
        held_t = '0;
        q8.delete();
        for (int c = 0; c < 10000; c++) begin
            iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
            s8 = 1'($urandom); tag8 = 4'($urandom); ordy8 = 1'($urandom);
            #1;
            if (held) begin
                total_cnt++;
                if (ov8 !== 1'b1 || prod8 !== held_p || otag8 !== held_t)
                    $display("FAIL rand_hold_%0d: got valid=%b prod=%h tag=%h want 1 %h %h", c, ov8, prod8, otag8, held_p, held_t);
                else pass_cnt++;
            end
            if (iv8 && ir8) q8.push_back('{p: ref8(a8, b8, s8), t: tag8});
            if (ov8 && ordy8) begin
                total_cnt++;
                if (q8.size() == 0) $display("FAIL rand_dup_%0d: got prod=%h want none", c, prod8);
                else begin
                    e = q8.pop_front();
                    if (prod8 !== e.p || otag8 !== e.t)
                        $display("FAIL rand_result_%0d: got prod=%h tag=%h want %h %h", c, prod8, otag8, e.p, e.t);
                    else pass_cnt++;
                end
            end
            held = ov8 && !ordy8;
            if (held) begin
                e = q8[0];
                held_p = e.p;
                held_t = e.t;
            end
            tick;
        end
        iv8 = 1'b0;
        ordy8 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ov8 && ordy8) begin
                total_cnt++;
                if (q8.size() == 0) $display("FAIL rand_drain_dup: got prod=%h want none", prod8);
                else begin
                    e = q8.pop_front();
                    if (prod8 !== e.p || otag8 !== e.t)
                        $display("FAIL rand_drain: got prod=%h tag=%h want %h %h", prod8, otag8, e.p, e.t);
                    else pass_cnt++;
                end
            end
            tick;
        end
        total_cnt++;
        if (q8.size() != 0) $display("FAIL rand_lost: got %0d undelivered want 0", q8.size()); else pass_cnt++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_unsigned_max;
        test_back_to_back;
        test_stall;
        test_reset_in_flight;
        test_exhaustive_w4;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
